// File: rtl/mem_stage_mc_if.sv
// Pipeline-side bus of the multi-cycle data-memory stage: request fields in,
// load result and stall/done/err handshake out.
interface mem_stage_mc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              mem_enable;
    logic              mem_write;
    logic [DATA_W-1:0] read_data;
    logic              stall;
    logic              done;
    logic              err;

    modport master (
        output addr, write_data, mem_enable, mem_write,
        input  read_data, stall, done, err
    );

    modport slave (
        input  addr, write_data, mem_enable, mem_write,
        output read_data, stall, done, err
    );
endinterface

// File: rtl/mem_stage_mc.sv
// Multi-cycle data-memory stage with IDLE/BUSY/DONE handshake and word aliasing.
// Optional misaligned-access trapping is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage_mc #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_mc_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_count;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_write;
    logic                  r_misalign;
    logic [DATA_W-1:0]     r_readData;
    logic                  r_done;
    logic                  r_err;
    logic [DATA_W-1:0]     r_mem [DEPTH];

    logic                  w_stall;
    logic                  w_accept;
    logic                  w_enterDone;
    logic                  w_reqMisalign;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DATA_W-1:0]     w_wdata;
    logic                  w_write;
    logic                  w_misalign;
    logic                  w_unused;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_reqMisalign = bus.addr[0];
`else
    assign w_reqMisalign = 1'b0;
`endif

    // Address bits outside the word index are intentionally ignored (aliasing).
    assign w_unused = ^bus.addr;

    assign w_accept    = (r_state == IDLE) && bus.mem_enable;
    assign w_enterDone = (w_next == DONE) && (r_state != DONE);

    // With LATENCY=1 the accept edge is also the commit edge, so use live inputs.
    assign w_idx      = (r_state == IDLE) ? bus.addr[DEPTH_LOG2:1] : r_idx;
    assign w_wdata    = (r_state == IDLE) ? bus.write_data         : r_wdata;
    assign w_write    = (r_state == IDLE) ? bus.mem_write          : r_write;
    assign w_misalign = (r_state == IDLE) ? w_reqMisalign          : r_misalign;

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = bus.mem_enable;
                if (bus.mem_enable) begin
                    w_next = (LATENCY > 1) ? BUSY : DONE;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (r_count == CNT_W'(1)) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The array is deliberately not reset; a store is only committed outside reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_misalign <= 1'b0;
            r_readData <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_enterDone;
            r_err   <= w_enterDone && w_misalign;
            if (w_accept) begin
                r_idx      <= bus.addr[DEPTH_LOG2:1];
                r_wdata    <= bus.write_data;
                r_write    <= bus.mem_write;
                r_misalign <= w_reqMisalign;
                r_count    <= CNT_W'(LATENCY - 1);
            end else if (r_state == BUSY) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_enterDone) begin
                if (w_misalign) begin
                    r_readData <= '0;
                end else if (w_write) begin
                    r_mem[w_idx] <= w_wdata;
                    r_readData   <= '0;
                end else begin
                    r_readData <= r_mem[w_idx];
                end
            end
        end
    end

    assign bus.stall     = rst && w_stall;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.read_data = r_readData;
endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc: a LATENCY=4 instance and a LATENCY=1 instance
// share the request fields; a select picks which one receives mem_enable.
module tb_mem_stage_mc;
`ifdef MEM_ALIGN_CHECK_EN
    localparam logic ALIGN = 1'b1;
`else
    localparam logic ALIGN = 1'b0;
`endif

    typedef struct {
        logic        sel;
        int          lat;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] expRead;
        logic        expErr;
        string       name;
    } vec_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        tSel   = 1'b0;
    logic        tEn    = 1'b0;
    logic        tWrite = 1'b0;
    logic [15:0] tAddr  = '0;
    logic [15:0] tWdata = '0;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[$];

    mem_stage_mc_if #(.DATA_W(16), .ADDR_W(16)) busA ();
    mem_stage_mc_if #(.DATA_W(16), .ADDR_W(16)) busB ();

    assign busA.addr       = tAddr;
    assign busA.write_data = tWdata;
    assign busA.mem_write  = tWrite;
    assign busA.mem_enable = tEn & ~tSel;
    assign busB.addr       = tAddr;
    assign busB.write_data = tWdata;
    assign busB.mem_write  = tWrite;
    assign busB.mem_enable = tEn & tSel;

    mem_stage_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(4)) dutA (
        .clk (clk),
        .rst (rst_n),
        .bus (busA)
    );

    mem_stage_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1)) dutB (
        .clk (clk),
        .rst (rst_n),
        .bus (busB)
    );

    logic        sStall;
    logic        sDone;
    logic        sErr;
    logic [15:0] sRead;
    assign sStall = tSel ? busB.stall     : busA.stall;
    assign sDone  = tSel ? busB.done      : busA.done;
    assign sErr   = tSel ? busB.err       : busA.err;
    assign sRead  = tSel ? busB.read_data : busA.read_data;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic sel, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] expRead,
                                input logic expErr, input string name);
        vec_t v;
        v.sel     = sel;
        v.lat     = sel ? 1 : 4;
        v.wr      = wr;
        v.addr    = addr;
        v.wdata   = wdata;
        v.expRead = expRead;
        v.expErr  = expErr;
        v.name    = name;
        return v;
    endfunction

    // Issue one request and check stall for cycles 0..lat-1 and done/data in cycle lat.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        tSel   = v.sel;
        tAddr  = v.addr;
        tWdata = v.wdata;
        tWrite = v.wr;
        tEn    = 1'b1;
        #1;
        checkOutput({v.name, " stall c0"}, {15'd0, sStall}, 16'd1);
        checkOutput({v.name, " done c0"},  {15'd0, sDone},  16'd0);
        for (int c = 1; c < v.lat; c++) begin
            @(negedge clk);
            checkOutput($sformatf("%s stall c%0d", v.name, c), {15'd0, sStall}, 16'd1);
            checkOutput($sformatf("%s done c%0d", v.name, c),  {15'd0, sDone},  16'd0);
        end
        @(negedge clk);
        checkOutput({v.name, " stall at done"}, {15'd0, sStall}, 16'd0);
        checkOutput({v.name, " done"},          {15'd0, sDone},  16'd1);
        checkOutput({v.name, " err"},           {15'd0, sErr},   {15'd0, v.expErr});
        checkOutput({v.name, " read_data"},     sRead,           v.expRead);
        tEn = 1'b0;
    endtask

    initial begin
        vecs.push_back(mk(1'b1, 1'b1, 16'h0030, 16'h1234, 16'h0000, 1'b0, "B st 0030"));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1234, 1'b0, "B ld 0030"));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0830, 16'h0000, 16'h1234, 1'b0, "B ld alias 0830"));
        vecs.push_back(mk(1'b1, 1'b1, 16'h0032, 16'h4321, 16'h0000, 1'b0, "B st 0032"));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0032, 16'h0000, 16'h4321, 1'b0, "B ld 0032"));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, "A st 0010"));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, "A ld 0010"));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0004, 16'hAAAA, 16'h0000, 1'b0, "A st 0004"));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0804, 16'h0000, 16'hAAAA, 1'b0, "A ld alias 0804"));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0, "A st 0020"));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, "A ld 0020"));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0011, 16'h2222, 16'h0000, ALIGN, "A st misaligned 0011"));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0010, 16'h0000, ALIGN ? 16'hBEEF : 16'h2222, 1'b0,
                          "A ld 0010 after misaligned st"));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0011, 16'h0000, ALIGN ? 16'h0000 : 16'h2222, ALIGN,
                          "A ld misaligned 0011"));
        vecs.push_back(mk(1'b0, 1'b1, 16'hFFFE, 16'h7777, 16'h0000, 1'b0, "A st top FFFE"));
        vecs.push_back(mk(1'b0, 1'b0, 16'h07FE, 16'h0000, 16'h7777, 1'b0, "A ld wrap 07FE"));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset A stall", {15'd0, busA.stall}, 16'd0);
        checkOutput("reset A done",  {15'd0, busA.done},  16'd0);
        checkOutput("reset A err",   {15'd0, busA.err},   16'd0);
        checkOutput("reset A read",  busA.read_data,      16'h0000);
        checkOutput("reset B done",  {15'd0, busB.done},  16'd0);
        checkOutput("reset B read",  busB.read_data,      16'h0000);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset in the middle of a store must drop it and clear outputs at once.
        @(negedge clk);
        tSel   = 1'b0;
        tAddr  = 16'h0020;
        tWdata = 16'h5555;
        tWrite = 1'b1;
        tEn    = 1'b1;
        #1;
        checkOutput("midrst stall c0", {15'd0, busA.stall}, 16'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst stall async", {15'd0, busA.stall}, 16'd0);
        checkOutput("midrst done",        {15'd0, busA.done},  16'd0);
        checkOutput("midrst read",        busA.read_data,      16'h0000);
        tEn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mk(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, "A ld 0020 after midrst"));

        // mem_write without mem_enable must neither stall nor touch the array.
        @(negedge clk);
        tAddr  = 16'h0010;
        tWdata = 16'hDEAD;
        tWrite = 1'b1;
        tEn    = 1'b0;
        #1;
        checkOutput("noen stall", {15'd0, busA.stall}, 16'd0);
        @(negedge clk);
        checkOutput("noen done",  {15'd0, busA.done},  16'd0);
        @(negedge clk);
        checkOutput("noen read hold", busA.read_data, 16'h1111);
        tWrite = 1'b0;
        applyStimulus(mk(1'b0, 1'b0, 16'h0010, 16'h0000, ALIGN ? 16'hBEEF : 16'h2222, 1'b0,
                         "A ld 0010 after noen"));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
